// File: rtl/cpu_pkg.sv
// cpu_pkg - shared constants and types for the R-type front end.
//   XLEN / REG_SELECT_LEN : datapath width and register-select width
//   OPCODE_OP            : major opcode of register-register ALU ops
//   FUNCT7_BASE/ALT      : the two legal funct7 encodings for R-type
//   FUNCT3_ADD_SUB/SRL_SRA : funct3 values that accept the ALT funct7
//   seq_state_t          : fetch_sequencer control states
package cpu_pkg;

  localparam int XLEN           = 32;
  localparam int REG_SELECT_LEN = 5;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

endpackage : cpu_pkg

// File: rtl/rtype_decode_check.sv
// rtype_decode_check - combinational legality check for R-type instructions.
// Ports:
//   opcode [6:0] : instruction[6:0]
//   funct3 [2:0] : instruction[14:12]
//   funct7 [6:0] : instruction[31:25]
//   valid        : high when the fields form a dispatchable R-type op
// Only the fields that decide legality are taken as inputs, so the
// register-select fields never appear as dangling inputs here.
module rtype_decode_check (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       valid
);

  import cpu_pkg::*;

  logic alt_ok;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    alt_ok = 1'b0;
    valid  = 1'b0;
    // The alternate funct7 only exists for sub and sra.
    alt_ok = (funct7 == FUNCT7_ALT) &&
             ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA));
    valid  = (opcode == OPCODE_OP) && ((funct7 == FUNCT7_BASE) || alt_ok);
  end

endmodule : rtype_decode_check

// File: rtl/fetch_sequencer.sv
// fetch_sequencer - fetches R-type instructions over a req/ack handshake,
// validates them, and sequences the execute enable and register write.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   mem_req/mem_addr: fetch request and address (address is always pc)
//   mem_ack/mem_rdata: fetch completion and instruction word
//   instruction     : latched instruction held for the execute stage
//   exec_enable_n   : active-low execute enable
//   reg_write_en    : register-file write strobe, last EXEC cycle only
//   pc              : current instruction address
//   illegal_instr   : sticky flag for an undispatchable instruction
//   halted          : high while parked in HALT
module fetch_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              EXEC_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            exec_enable_n,
  output logic            reg_write_en,
  output logic [XLEN-1:0] pc,
  output logic            illegal_instr,
  output logic            halted
);

  import cpu_pkg::*;

  // Counter only has to hold EXEC_CYCLES-1.
  localparam int CNT_W = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES) : 1;

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             instr_valid;

  rtype_decode_check u_check (
    .opcode (instruction[6:0]),
    .funct3 (instruction[14:12]),
    .funct7 (instruction[31:25]),
    .valid  (instr_valid)
  );

  // The fetch address is the PC itself; both are registered, so the
  // address is stable for the whole request.
  assign mem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Reset wins over everything, including an ack in the same cycle.
      state         <= RST;
      pc            <= RESET_PC;
      instruction   <= '0;
      mem_req       <= 1'b0;
      exec_enable_n <= 1'b1;
      reg_write_en  <= 1'b0;
      illegal_instr <= 1'b0;
      halted        <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        RST: begin
          mem_req <= 1'b1;
          state   <= FETCH;
        end

        FETCH: begin
          if (mem_ack) begin
            instruction <= mem_rdata;
            mem_req     <= 1'b0;
            state       <= DECODE;
          end
        end

        DECODE: begin
          if (instr_valid) begin
            cnt           <= CNT_W'(EXEC_CYCLES - 1);
            exec_enable_n <= 1'b0;
            state         <= EXEC;
          end else begin
            illegal_instr <= 1'b1;
            halted        <= 1'b1;
            state         <= HALT;
          end
        end

        EXEC: begin
          if (cnt == '0) begin
            exec_enable_n <= 1'b1;
            reg_write_en  <= 1'b0;
            state         <= WB;
          end else begin
            cnt          <= cnt - CNT_W'(1);
            // Raise the strobe as the counter enters its final value so it
            // coincides with the last EXEC cycle.
            reg_write_en <= (cnt == CNT_W'(1));
          end
        end

        WB: begin
          pc      <= pc + XLEN'(4);
          mem_req <= 1'b1;
          state   <= FETCH;
        end

        HALT: begin
          // Parked until reset; all outputs hold.
        end

        default: begin
          state <= RST;
        end
      endcase
    end
  end

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer - directed self-checking bench for fetch_sequencer.
// Three instances share clock, reset and memory stimulus:
//   u_dut  : default parameters (main sequence)
//   u_wrap : RESET_PC = 32'hFFFF_FFFC (pc wrap)
//   u_slow : EXEC_CYCLES = 3
module tb_fetch_sequencer;

  localparam logic [31:0] ADD_X3  = 32'h002081B3;
  localparam logic [31:0] SUB_X2  = 32'h40208133;
  localparam logic [31:0] ADDI    = 32'h00000013;
  localparam logic [31:0] ALT_XOR = 32'h4020C1B3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        d_req, d_en_n, d_we, d_ill, d_halt;
  logic [31:0] d_addr, d_instr, d_pc;
  logic        w_req, w_en_n, w_we, w_ill, w_halt;
  logic [31:0] w_addr, w_instr, w_pc;
  logic        s_req, s_en_n, s_we, s_ill, s_halt;
  logic [31:0] s_addr, s_instr, s_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .mem_req(d_req), .mem_addr(d_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(d_instr),
    .exec_enable_n(d_en_n), .reg_write_en(d_we), .pc(d_pc),
    .illegal_instr(d_ill), .halted(d_halt)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .mem_req(w_req), .mem_addr(w_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(w_instr),
    .exec_enable_n(w_en_n), .reg_write_en(w_we), .pc(w_pc),
    .illegal_instr(w_ill), .halted(w_halt)
  );

  fetch_sequencer #(.EXEC_CYCLES(3)) u_slow (
    .clk(clk), .rst_n(rst_n), .mem_req(s_req), .mem_addr(s_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(s_instr),
    .exec_enable_n(s_en_n), .reg_write_en(s_we), .pc(s_pc),
    .illegal_instr(s_ill), .halted(s_halt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick(2);

    // ---- reset state
    check("rst_req",   d_req,   0);
    check("rst_pc",    d_pc,    0);
    check("rst_instr", d_instr, 0);
    check("rst_en_n",  d_en_n,  1);
    check("rst_we",    d_we,    0);
    check("rst_ill",   d_ill,   0);
    check("rst_halt",  d_halt,  0);
    check("rst_pc_wrap", w_pc, 32'hFFFF_FFFC);

    // ---- test 1: 0-wait add at pc 0
    rst_n = 1'b1;
    tick();                               // E0: RST -> FETCH
    check("t1_req_up",  d_req,  1);
    check("t1_addr",    d_addr, 0);
    mem_ack = 1'b1; mem_rdata = ADD_X3;
    tick();                               // E1: ack, -> DECODE
    check("t1_instr",   d_instr, ADD_X3);
    check("t1_req_dn",  d_req,   0);
    check("t1_en_dec",  d_en_n,  1);
    mem_ack = 1'b0;
    tick();                               // E2: EXEC cycle 1
    check("t1_en_x1",   d_en_n, 0);
    check("t1_we_x1",   d_we,   0);
    check("s6_en_x1",   s_en_n, 0);
    check("s6_we_x1",   s_we,   0);
    tick();                               // E3: EXEC cycle 2
    check("t1_en_x2",   d_en_n, 0);
    check("t1_we_x2",   d_we,   1);
    check("s6_en_x2",   s_en_n, 0);
    check("s6_we_x2",   s_we,   0);
    tick();                               // E4: WB
    check("t1_en_wb",   d_en_n, 1);
    check("t1_we_wb",   d_we,   0);
    check("t1_req_wb",  d_req,  0);
    check("t1_pc_wb",   d_pc,   0);
    check("s6_en_x3",   s_en_n, 0);
    check("s6_we_x3",   s_we,   1);
    tick();                               // E5: next FETCH
    check("t1_req_next", d_req,  1);
    check("t1_pc_next",  d_pc,   4);
    check("t1_addr_next", d_addr, 4);
    check("t5_pc_wrap",   w_pc,   0);
    check("t5_addr_wrap", w_addr, 0);
    check("s6_en_wb",     s_en_n, 1);
    check("s6_we_wb",     s_we,   0);

    // ---- test 2: ack delayed 3 cycles, sub at pc 4
    mem_rdata = SUB_X2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_wait_req",   d_req,   1);
      check("t2_wait_addr",  d_addr,  4);
      check("t2_wait_instr", d_instr, ADD_X3);
    end
    check("s6_req_next", s_req, 1);
    check("s6_pc_next",  s_pc,  4);
    mem_ack = 1'b1;
    tick();                               // ack edge
    check("t2_instr", d_instr, SUB_X2);
    check("t2_req_dn", d_req,  0);
    mem_ack = 1'b0;
    tick();                               // EXEC cycle 1
    check("t2_en_x1", d_en_n, 0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();                               // EXEC cycle 2, spurious ack
    check("t2_spur_instr", d_instr, SUB_X2);
    check("t2_we_x2", d_we, 1);
    mem_ack = 1'b0;
    tick();                               // WB
    check("t2_spur_instr_wb", d_instr, SUB_X2);
    tick();                               // FETCH at 8
    check("t2_pc_next", d_pc, 8);
    check("t2_req_next", d_req, 1);

    // ---- test 3a: addi at pc 8 halts
    mem_ack = 1'b1; mem_rdata = ADDI;
    tick();
    check("t3_instr", d_instr, ADDI);
    mem_ack = 1'b0;
    tick();                               // DECODE -> HALT
    check("t3_ill",  d_ill,  1);
    check("t3_halt", d_halt, 1);
    check("t3_en_n", d_en_n, 1);
    check("t3_we",   d_we,   0);
    mem_ack = 1'b1; mem_rdata = ADD_X3;
    tick(2);
    check("t3_pc_frozen", d_pc,   8);
    check("t3_no_req",    d_req,  0);
    check("t3_no_we",     d_we,   0);
    check("t3_halt_hold", d_halt, 1);
    check("t3_instr_hold", d_instr, ADDI);
    mem_ack = 1'b0;

    // ---- test 3b: funct7 alt with xor halts
    rst_n = 1'b0;
    tick();
    check("t3b_rst_ill",  d_ill,  0);
    check("t3b_rst_halt", d_halt, 0);
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = ALT_XOR;
    tick();
    mem_ack = 1'b0;
    tick();
    check("t3b_ill",  d_ill,  1);
    check("t3b_halt", d_halt, 1);
    check("t3b_en_n", d_en_n, 1);
    check("t3b_pc",   d_pc,   0);
    tick();
    check("t3b_no_req", d_req, 0);

    // ---- test 4: reset during EXEC (retire one add first so pc != 0)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();                               // FETCH
    mem_ack = 1'b1; mem_rdata = ADD_X3;
    tick();                               // ack
    mem_ack = 1'b0;
    tick(4);                              // EXEC, EXEC, WB, FETCH
    check("t4_pc_pre", d_pc, 4);
    mem_ack = 1'b1;
    tick();                               // ack
    mem_ack = 1'b0;
    tick();                               // EXEC cycle 1
    check("t4_en_pre", d_en_n, 0);
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = SUB_X2;
    tick();                               // reset edge, ack ignored
    check("t4_en_n", d_en_n, 1);
    check("t4_we",   d_we,   0);
    check("t4_pc",   d_pc,   0);
    check("t4_req",  d_req,  0);
    check("t4_instr", d_instr, 0);
    rst_n = 1'b1; mem_ack = 1'b0;
    tick();
    check("t4_refetch_req",  d_req,  1);
    check("t4_refetch_addr", d_addr, 0);
    mem_ack = 1'b1; mem_rdata = ADD_X3;
    tick();
    check("t4_refetch_instr", d_instr, ADD_X3);
    mem_ack = 1'b0;
    tick();
    check("t4_refetch_en", d_en_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Upstream control stage for the R-type execute block (the register-register ALU stage). It fetches 32-bit instructions from instruction memory over a req/ack handshake and holds each one stable. It decodes and validates the opcode, then sequences the active-low execute enable and the register-file write strobe. It owns the PC, advancing it by 4 after each retired instruction, and halts on any instruction it cannot dispatch.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
EXEC_CYCLES, 2, cycles execute enable is held low; minimum 2, because register selects are registered in the execute stage

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
mem_req  out  1  fetch request to instruction memory
mem_addr  out  XLEN  fetch address, equals pc
mem_ack  in  1  memory has valid mem_rdata this cycle
mem_rdata  in  XLEN  fetched instruction word
instruction  out  XLEN  latched instruction, drives execute stage
exec_enable_n  out  1  active-low enable to R-type execute stage
reg_write_en  out  1  register-file write strobe for output register/data
pc  out  XLEN  current instruction address
illegal_instr  out  1  sticky, set on undispatchable instruction
halted  out  1  high in HALT state

Behaviour:
- Reset (rst_n low at a rising edge): state=RST. Outputs: pc=RESET_PC, instruction=0, mem_req=0, exec_enable_n=1, reg_write_en=0, illegal_instr=0, halted=0.
- Reset asserted mid-operation aborts everything. An in-flight fetch is dropped, and any mem_ack in that cycle is ignored.
- States are RST, FETCH, DECODE, EXEC, WB, HALT. All outputs are registered or decoded only from registered state.
- RST: always goes to FETCH on the next cycle.
- FETCH:
  - mem_req=1 and mem_addr=pc, both held stable until mem_ack is sampled high.
  - On the ack edge: instruction<=mem_rdata, go to DECODE.
  - mem_req is 0 from the following cycle.
  - mem_ack while not in FETCH is ignored.
  - The wait is unbounded; there is no timeout.
- DECODE (1 cycle): checks the latched instruction.
  - Valid means opcode[6:0]=7'b0110011, funct7 in {7'b0000000, 7'b0100000}, and funct7=7'b0100000 only with funct3 in {3'b000, 3'b101}.
  - Valid: go to EXEC with the cycle counter loaded to EXEC_CYCLES-1.
  - Invalid: set illegal_instr and go to HALT.
- EXEC:
  - exec_enable_n=0 and instruction held.
  - The counter decrements each cycle; at 0 go to WB.
  - reg_write_en=1 only in the last EXEC cycle (counter==0).
- WB (1 cycle):
  - exec_enable_n=1, reg_write_en=0.
  - pc<=pc+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
  - Go to FETCH.
- HALT:
  - halted=1, exec_enable_n=1, mem_req=0, pc frozen at the offending instruction.
  - Exit only by reset.
- Writes to rd=x0 are not filtered; the register file ignores them.
- Latency per valid instruction: fetch wait (W cycles) + 1 ack cycle + 1 DECODE + EXEC_CYCLES + 1 WB. With a 0-wait memory and EXEC_CYCLES=2 that is 5 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN and REG_SELECT_LEN constants
  - OPCODE_OP=7'b0110011
  - FUNCT7_BASE and FUNCT7_ALT constants
  - typedef enum seq_state_t {RST, FETCH, DECODE, EXEC, WB, HALT}
- One sub-module: rtype_decode_check, a combinational instruction->valid checker. It is reused later when I-type support is added.

Test Plan:
1. Reset + 0-wait fetch of 32'h002081B3 (add x3,x1,x2) at pc=0:
   - mem_req high 1 cycle after reset release.
   - exec_enable_n low exactly 2 cycles, reg_write_en pulse on the 2nd.
   - pc=4 and next mem_req 5 cycles after the first.
2. Memory ack delayed 3 cycles with mem_rdata=32'h40208133 (sub):
   - mem_addr stable and mem_req high throughout the wait.
   - instruction latched only on the ack edge; spurious mem_ack during EXEC ignored.
3. Illegal instructions:
   - 32'h00000013 (addi) at pc=8 -> illegal_instr=1, halted=1, pc stays 8, no reg_write_en, no further mem_req.
   - 32'h4020C1B3 (funct7 alt with xor) gives the same result.
4. rst_n low for 1 cycle during EXEC -> next cycle exec_enable_n=1, reg_write_en=0, pc=RESET_PC, then a clean fetch restarts from RESET_PC.
5. RESET_PC=32'hFFFF_FFFC with a valid add -> after WB pc=0 and mem_addr=0.
6. EXEC_CYCLES=3 build -> exec_enable_n low 3 cycles, reg_write_en only in the 3rd.
